ball_hit_edge_detector: RTL and testbench

// - Produces the collision pulse and HitEdgeCode that the white-ball motion block consumes.
// - Sits between the VGA drawing-request mux and the ball motion block.
// - Watches every scanned pixel where the ball and an obstacle overlap. Works out which ball edge touched.
// - After each frame's scan, emits one collision pulse with the edges that were touched.

---
 rtl/ball_hit_edge_detector_pkg.sv | 11 +
 rtl/ball_hit_edge_detector_if.sv | 21 ++
 rtl/ball_hit_edge_detector_classifier.sv | 23 ++
 rtl/ball_hit_edge_detector.sv | 89 ++++++++
 tb/tb_ball_hit_edge_detector.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ball_hit_edge_detector_pkg.sv
// billiard_pkg: edge-code type, edge bit positions and detector FSM states shared by the hit detectors.
package billiard_pkg;
  typedef logic [3:0] edge_code_t;
  localparam int EDGE_LEFT = 3;
  localparam int EDGE_TOP = 2;
  localparam int EDGE_RIGHT = 1;
  localparam int EDGE_BOTTOM = 0;
  localparam edge_code_t X_EDGES = 4'b1010;
  localparam edge_code_t Y_EDGES = 4'b0101;
  typedef enum logic [1:0] {ACCUM, REPORT, HOLDOFF} det_state_t;
endpackage

// File: rtl/ball_hit_edge_detector_if.sv
// ball_hit_edge_detector_if: pixel scan inputs, ball position and collision report of the edge detector.
interface ball_hit_edge_detector_if;
  import billiard_pkg::*;
  logic startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic ballDR;
  logic obstacleDR;
  logic signed [10:0] ballTopLeftX;
  logic signed [10:0] ballTopLeftY;
  logic collision;
  edge_code_t HitEdgeCode;
  modport master(
    output startOfFrame, pixelX, pixelY, ballDR, obstacleDR, ballTopLeftX, ballTopLeftY,
    input collision, HitEdgeCode
  );
  modport slave(
    input startOfFrame, pixelX, pixelY, ballDR, obstacleDR, ballTopLeftX, ballTopLeftY,
    output collision, HitEdgeCode
  );
endinterface

// File: rtl/ball_hit_edge_detector_classifier.sv
// hit_edge_classifier: maps one overlapping pixel's offset inside the ball to the ball edges it touches.
module hit_edge_classifier
  import billiard_pkg::*;
#(
  parameter int BALL_SIZE = 32,
  parameter int EDGE_MARGIN = 4
) (
  input logic hit,
  input logic signed [11:0] offX,
  input logic signed [11:0] offY,
  output edge_code_t edgeCode
);
  logic inBall;
  assign inBall = hit && !offX[11] && !offY[11]
                  && offX[10:0] < 11'(BALL_SIZE) && offY[10:0] < 11'(BALL_SIZE);
  always_comb begin
    edgeCode = '0;
    edgeCode[EDGE_LEFT] = inBall && offX[10:0] < 11'(EDGE_MARGIN);
    edgeCode[EDGE_TOP] = inBall && offY[10:0] < 11'(EDGE_MARGIN);
    edgeCode[EDGE_RIGHT] = inBall && offX[10:0] >= 11'(BALL_SIZE - EDGE_MARGIN);
    edgeCode[EDGE_BOTTOM] = inBall && offY[10:0] >= 11'(BALL_SIZE - EDGE_MARGIN);
  end
endmodule

// File: rtl/ball_hit_edge_detector.sv
// ball_hit_edge_detector: accumulates touched ball edges per frame, reports once per frame with holdoff.
// Optional EDGE_VOTE_EN keeps only the axis with more touching pixels when a corner is hit.
module ball_hit_edge_detector
  import billiard_pkg::*;
#(
  parameter int BALL_SIZE = 32,
  parameter int EDGE_MARGIN = 4,
  parameter int HOLDOFF_FRAMES = 2
) (
  input logic clk,
  input logic reset,
  ball_hit_edge_detector_if.slave bus
);
  localparam int HW = HOLDOFF_FRAMES > 0 ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  det_state_t state, nextState;
  logic [10:0] pixelX1, pixelY1;
  logic ballDR1, obstacleDR1, sof1, sof2;
  logic signed [11:0] offX, offY;
  edge_code_t pixelEdges, edges2, acc, snap, reportCode;
  logic [HW-1:0] holdCnt;
  assign offX = 12'(pixelX1) - 12'(bus.ballTopLeftX);
  assign offY = 12'(pixelY1) - 12'(bus.ballTopLeftY);
  hit_edge_classifier #(.BALL_SIZE(BALL_SIZE), .EDGE_MARGIN(EDGE_MARGIN)) classifier (
    .hit(ballDR1 & obstacleDR1),
    .offX(offX),
    .offY(offY),
    .edgeCode(pixelEdges)
  );
  // edges2 and sof2 are aligned, so a hit arriving with sof2 opens the new frame
  always_ff @(posedge clk)
    if (reset) begin
      pixelX1 <= '0;
      pixelY1 <= '0;
      ballDR1 <= 1'b0;
      obstacleDR1 <= 1'b0;
      sof1 <= 1'b0;
      sof2 <= 1'b0;
      edges2 <= '0;
      acc <= '0;
      snap <= '0;
      holdCnt <= '0;
    end else begin
      pixelX1 <= bus.pixelX;
      pixelY1 <= bus.pixelY;
      ballDR1 <= bus.ballDR;
      obstacleDR1 <= bus.obstacleDR;
      sof1 <= bus.startOfFrame;
      sof2 <= sof1;
      edges2 <= pixelEdges;
      acc <= sof2 ? edges2 : acc | edges2;
      if (state == ACCUM && sof2) snap <= reportCode;
      if (state == REPORT) holdCnt <= HW'(HOLDOFF_FRAMES);
      else if (state == HOLDOFF && sof2) holdCnt <= holdCnt - 1'b1;
    end
`ifdef EDGE_VOTE_EN
  logic [7:0] edgeCnt [4];
  logic [8:0] xSum, ySum;
  logic hasX, hasY;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      edgeCnt[i] <= reset ? 8'd0
                  : sof2 ? 8'(edges2[i])
                  : edgeCnt[i] + 8'(edges2[i] && edgeCnt[i] != 8'hff);
  assign xSum = 9'(edgeCnt[EDGE_LEFT]) + 9'(edgeCnt[EDGE_RIGHT]);
  assign ySum = 9'(edgeCnt[EDGE_TOP]) + 9'(edgeCnt[EDGE_BOTTOM]);
  assign hasX = |(acc & X_EDGES);
  assign hasY = |(acc & Y_EDGES);
  always_comb
    reportCode = !(hasX && hasY) ? acc
               : xSum > ySum ? acc & X_EDGES
               : ySum > xSum ? acc & Y_EDGES
               : acc;
`else
  assign reportCode = acc;
`endif
  always_ff @(posedge clk)
    if (reset) state <= ACCUM;
    else state <= nextState;
  always_comb
    nextState = state == REPORT ? (HOLDOFF_FRAMES > 0 ? HOLDOFF : ACCUM)
              : !sof2 ? state
              : state == ACCUM && acc != '0 ? REPORT
              : state == HOLDOFF && holdCnt == HW'(1) ? ACCUM
              : state;
  always_comb begin
    bus.collision = state == REPORT;
    bus.HitEdgeCode = state == REPORT ? snap : '0;
  end
endmodule

// File: tb/tb_ball_hit_edge_detector.sv
// tb_ball_hit_edge_detector: frame-level reference model feeding a scoreboard checked every cycle.
module tb_ball_hit_edge_detector;
  import billiard_pkg::*;
  localparam int HOLD = 2;
  localparam int BS = 32;
  localparam int EM = 4;
  typedef struct packed {int cyc; logic [3:0] code;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ball_hit_edge_detector_if bus();
  ball_hit_edge_detector #(.BALL_SIZE(BS), .EDGE_MARGIN(EM), .HOLDOFF_FRAMES(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  exp_t expQ[$];
  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;
  int pulses = 0;
  int tlX = 100;
  int tlY = 220;
  int hold = 0;
  int ovX[$];
  int ovY[$];
  logic [3:0] fCode = 4'b0;
  logic [3:0] lastCode = 4'b0;
  bit due;
`ifdef EDGE_VOTE_EN
  int fCnt[4] = '{0, 0, 0, 0};
`endif
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] classify(input int px, input int py);
    int ox = px - tlX;
    int oy = py - tlY;
    if (ox < 0 || oy < 0 || ox >= BS || oy >= BS) return 4'b0;
    return {ox < EM, oy < EM, ox >= BS - EM, oy >= BS - EM};
  endfunction

  function automatic void clearFrame();
    fCode = 4'b0;
`ifdef EDGE_VOTE_EN
    for (int i = 0; i < 4; i++) fCnt[i] = 0;
`endif
  endfunction

  // the frame just ended is decided at its closing startOfFrame; pulse lands 3 cycles later
  function automatic void closeFrame();
    logic [3:0] c = fCode;
`ifdef EDGE_VOTE_EN
    int xs = fCnt[EDGE_LEFT] + fCnt[EDGE_RIGHT];
    int ys = fCnt[EDGE_TOP] + fCnt[EDGE_BOTTOM];
    if ((c[EDGE_LEFT] || c[EDGE_RIGHT]) && (c[EDGE_TOP] || c[EDGE_BOTTOM])) begin
      if (xs > ys) c = c & 4'b1010;
      else if (ys > xs) c = c & 4'b0101;
    end
`endif
    if (hold > 0) hold--;
    else if (c != 4'b0) begin
      expQ.push_back('{cyc + 3, c});
      hold = HOLD;
    end
    clearFrame();
  endfunction

  task automatic drive(input int px, input int py, input bit b, input bit o, input bit s);
    logic [3:0] e;
    @(posedge clk);
    #1;
    bus.startOfFrame = s;
    bus.pixelX = 11'(px);
    bus.pixelY = 11'(py);
    bus.ballDR = b;
    bus.obstacleDR = o;
    bus.ballTopLeftX = 11'(tlX);
    bus.ballTopLeftY = 11'(tlY);
    if (s) closeFrame();
    if (b && o) begin
      e = classify(px, py);
      fCode = fCode | e;
`ifdef EDGE_VOTE_EN
      for (int i = 0; i < 4; i++) if (e[i] && fCnt[i] < 255) fCnt[i]++;
`endif
    end
  endtask

  task automatic idle();
    bit b = 1'($urandom_range(0, 1));
    drive(tlX + int'($urandom_range(0, BS - 1)), tlY + int'($urandom_range(0, BS - 1)), b, !b, 1'b0);
  endtask

  task automatic frame(input int nRand);
    int px, py;
    drive(tlX, tlY, 1'b0, 1'b0, 1'b1);
    foreach (ovX[i]) drive(ovX[i], ovY[i], 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < nRand; i++) begin
      px = tlX + int'($urandom_range(0, BS + 15)) - 8;
      py = tlY + int'($urandom_range(0, BS + 15)) - 8;
      drive(px < 0 ? 0 : px, py < 0 ? 0 : py, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (2) idle();
    ovX.delete();
    ovY.delete();
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.ballDR = 1'b0;
    bus.obstacleDR = 1'b0;
    hold = 0;
    clearFrame();
    expQ.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk)
    if (!reset) begin
      due = expQ.size() > 0 && expQ[0].cyc == cyc;
      check("collision", int'(bus.collision), int'(due));
      check("HitEdgeCode", int'(bus.HitEdgeCode), due ? int'(expQ[0].code) : 0);
      if (bus.collision) begin
        pulses++;
        lastCode = bus.HitEdgeCode;
      end
      if (due) void'(expQ.pop_front());
    end

  initial begin
    int p0;
    bus.startOfFrame = 1'b0;
    bus.pixelX = '0;
    bus.pixelY = '0;
    bus.ballDR = 1'b0;
    bus.obstacleDR = 1'b0;
    bus.ballTopLeftX = 11'(tlX);
    bus.ballTopLeftY = 11'(tlY);
    doReset(2);
    check("reset collision", int'(bus.collision), 0);
    check("reset HitEdgeCode", int'(bus.HitEdgeCode), 0);
    repeat (3) frame(0);
    check("idle pulses", pulses, 0);
    // left edge
    ovX = '{100};
    ovY = '{230};
    frame(0);
    repeat (3) frame(0);
    check("left pulses", pulses, 1);
    check("left code", int'(lastCode), 4'b1000);
    // bottom edge
    ovX = '{116};
    ovY = '{251};
    frame(0);
    repeat (3) frame(0);
    check("bottom pulses", pulses, 2);
    check("bottom code", int'(lastCode), 4'b0001);
    // interior only
    ovX = '{116};
    ovY = '{236};
    frame(0);
    repeat (3) frame(0);
    check("interior pulses", pulses, 2);
    // corner
    ovX = '{100, 101, 102};
    ovY = '{220, 220, 220};
`ifdef EDGE_VOTE_EN
    for (int i = 10; i <= 14; i++) begin
      ovX.push_back(100);
      ovY.push_back(220 + i);
    end
`endif
    frame(0);
    repeat (3) frame(0);
    check("corner pulses", pulses, 3);
`ifdef EDGE_VOTE_EN
    check("corner code", int'(lastCode), 4'b1000);
`else
    check("corner code", int'(lastCode), 4'b1100);
`endif
    // holdoff: four consecutive hit frames report first and fourth
    for (int f = 0; f < 4; f++) begin
      ovX = '{100};
      ovY = '{230};
      frame(0);
    end
    repeat (3) frame(0);
    check("holdoff pulses", pulses, 5);
    // reset during holdoff clears it
    ovX = '{100};
    ovY = '{230};
    frame(0);
    drive(tlX, tlY, 1'b0, 1'b0, 1'b1);
    repeat (5) idle();
    check("pre-reset pulses", pulses, 6);
    doReset(2);
    repeat (2) idle();
    ovX = '{100};
    ovY = '{230};
    frame(0);
    repeat (3) frame(0);
    check("post-reset pulses", pulses, 7);
    check("post-reset code", int'(lastCode), 4'b1000);
    // randomized frames, including negative ball positions
    p0 = pulses;
    for (int f = 0; f < 60; f++) begin
      tlX = int'($urandom_range(0, 1040)) - 40;
      tlY = int'($urandom_range(0, 740)) - 40;
      frame(int'($urandom_range(4, 16)));
    end
    repeat (3) frame(0);
    check("random produced pulses", int'(pulses > p0), 1);
    check("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
